// File: rtl/dma_desc_fetch_reg.sv
// Descriptor fetch engine: reads NumWords consecutive words over a register-interface
// master, presents them as one descriptor, and optionally follows the word-0 next pointer.
module dma_desc_fetch_reg #(
  parameter int unsigned AddrWidth = 64,
  parameter int unsigned DataWidth = 64,
  parameter int unsigned NumWords  = 4,
  parameter bit          ChainEn   = 1'b1,
  parameter type reg_req_t = struct packed {
    logic [AddrWidth-1:0]   addr;
    logic                   write;
    logic [DataWidth-1:0]   wdata;
    logic [DataWidth/8-1:0] wstrb;
    logic                   valid;
  },
  parameter type reg_rsp_t = struct packed {
    logic [DataWidth-1:0] rdata;
    logic                 error;
    logic                 ready;
  }
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic [AddrWidth-1:0]          start_addr_i,
  input  logic                          start_valid_i,
  output logic                          start_ready_o,
  input  logic                          abort_i,
  output reg_req_t                      reg_req_o,
  input  reg_rsp_t                      reg_rsp_i,
  output logic [NumWords*DataWidth-1:0] desc_o,
  output logic                          desc_error_o,
  output logic                          desc_valid_o,
  input  logic                          desc_ready_i,
  output logic                          busy_o,
  output logic [15:0]                   desc_count_o
);

  localparam int unsigned BytesPerWord = DataWidth / 8;
  localparam int unsigned CntWidth     = $clog2(NumWords);
  localparam logic [AddrWidth-1:0] AlignMask = ~AddrWidth'(BytesPerWord - 1);
  localparam logic [AddrWidth-1:0] AddrStep  = AddrWidth'(BytesPerWord);
  localparam logic [CntWidth-1:0]  LastCnt   = CntWidth'(NumWords - 1);

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    EMIT
  } state_e;

  state_e                state_q;
  logic [CntWidth-1:0]   cnt_q;
  logic                  err_q;
  logic                  abort_q;
  logic [AddrWidth-1:0]  next_base;
  logic                  chain_ok;

  assign start_ready_o = (state_q == IDLE);
  assign busy_o        = (state_q != IDLE);
  assign desc_error_o  = err_q;

  // Next pointer lives in word 0; all-ones terminates the chain.
  always_comb begin
    next_base = AddrWidth'(desc_o[DataWidth-1:0]) & AlignMask;
    chain_ok  = ChainEn && !abort_q && !abort_i && !err_q &&
                (desc_o[DataWidth-1:0] != '1);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      err_q        <= 1'b0;
      abort_q      <= 1'b0;
      reg_req_o    <= '0;
      desc_o       <= '0;
      desc_valid_o <= 1'b0;
      desc_count_o <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (start_valid_i) begin
            reg_req_o.addr  <= start_addr_i & AlignMask;
            reg_req_o.write <= 1'b0;
            reg_req_o.wdata <= '0;
            reg_req_o.wstrb <= '0;
            reg_req_o.valid <= 1'b1;
            cnt_q           <= '0;
            err_q           <= 1'b0;
            abort_q         <= 1'b0;
            state_q         <= FETCH;
          end
        end
        FETCH: begin
          if (abort_i) abort_q <= 1'b1;
          if (reg_rsp_i.ready) begin
            desc_o[cnt_q*DataWidth +: DataWidth] <= reg_rsp_i.rdata;
            err_q <= err_q | reg_rsp_i.error;
            // An abort seen at or before this handshake drops the partial descriptor.
            if (abort_q || abort_i) begin
              reg_req_o.valid <= 1'b0;
              state_q         <= IDLE;
            end else if (cnt_q == LastCnt) begin
              reg_req_o.valid <= 1'b0;
              desc_valid_o    <= 1'b1;
              state_q         <= EMIT;
            end else begin
              cnt_q          <= cnt_q + CntWidth'(1);
              reg_req_o.addr <= reg_req_o.addr + AddrStep;
            end
          end
        end
        EMIT: begin
          if (abort_i) abort_q <= 1'b1;
          if (desc_ready_i) begin
            desc_valid_o <= 1'b0;
            desc_count_o <= desc_count_o + 16'd1;
            if (chain_ok) begin
              reg_req_o.addr  <= next_base;
              reg_req_o.valid <= 1'b1;
              cnt_q           <= '0;
              err_q           <= 1'b0;
              state_q         <= FETCH;
            end else begin
              state_q <= IDLE;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule
